regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port between two writers: the pipeline writeback stage (WB) and an auxiliary long-latency unit (AUX, e.g. multiply/divide).
- WB normally has priority. AUX writes queue in a small FIFO and drain into idle WB cycles.
- A starvation counter stalls WB when needed to force an AUX slot.
- Exports a pending-register mask so hazard detection can stall readers of queued registers.

Parameters:
- WORD_SIZE, 16, data width (matches `WORD_SIZE).
- NUM_REGS, 4, register count (matches `NUM_MAX_REGISTER); dest width is clog2(NUM_REGS)=2.
- AUX_DEPTH, 2, AUX FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, cycles a FIFO head may wait before WB is stalled (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  WB has a register write this cycle.
- wb_dest  in  2  WB destination register.
- wb_data  in  WORD_SIZE  WB write data.
- wb_stall  out  1  WB must hold its request; the write port is granted to AUX this cycle.
- aux_valid  in  1  AUX offers a write.
- aux_ready  out  1  FIFO can accept; transfer when aux_valid & aux_ready at posedge.
- aux_dest  in  2  AUX destination register.
- aux_data  in  WORD_SIZE  AUX write data.
- rf_reg_write  out  1  register file write enable.
- rf_dest  out  2  register file write address.
- rf_write_data  out  WORD_SIZE  register file write data.
- pending_mask  out  NUM_REGS  bit r = 1 when any queued AUX entry targets register r.
- collision_err  out  1  sticky protocol-violation flag.

Behaviour:
- State: FIFO (dest, data) x AUX_DEPTH, rd_ptr, wr_ptr, count (0..AUX_DEPTH), age counter, collision_err. All cleared on reset_n=0, asynchronously.
- Reset values: count=0, age=0, aux_ready=1, wb_stall=0, rf_reg_write=0, pending_mask=0, collision_err=0. rf_dest and rf_write_data are 0 while no write is granted.
- aux_ready = (count < AUX_DEPTH), from registered count only. There is no pass-through when full, even if a dequeue happens in the same cycle.
- wb_stall = (count>0) & (age >= STARVE_LIMIT). It is combinational from registered state.
- Grant, evaluated each cycle (combinational drive of the rf_* outputs):
  - wb_stall=1: AUX head is granted. WB is not written; the pipeline re-presents the same WB request next cycle.
  - else wb_valid=1: WB is granted, with zero latency from wb_* to rf_*.
  - else count>0: AUX head is granted.
  - else rf_reg_write=0.
- Dequeue occurs on the posedge after an AUX grant; rd_ptr increments and wraps mod AUX_DEPTH.
- AUX latency: an entry accepted at edge N can be written no earlier than the cycle following edge N, i.e. 1 cycle minimum. There is no bypass from aux_* to rf_*.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at count = AUX_DEPTH only on the dequeue side, since aux_ready=0 then.
- Age counter:
  - Reset to 0 when count becomes 0, or on a dequeue.
  - Otherwise increments each cycle the head is present but not granted.
  - Saturates at STARVE_LIMIT.
- Consequence: after a stall grant the age restarts, so WB gets at least STARVE_LIMIT consecutive priority cycles per queued entry.
- pending_mask is an OR over valid FIFO entries of the one-hot dest. It includes the head while it is being written; the bit clears the cycle after the dequeue edge.
- Ordering rule: the hazard unit must not issue an instruction whose WB dest is in pending_mask.
  - If wb_valid & grant-to-WB & pending_mask[wb_dest], the write still occurs.
  - collision_err sets at that edge and holds until reset.
- AUX entries with the same dest drain in FIFO order.
- Reset mid-operation discards all queued entries with no write issued. aux_ready returns to 1 immediately while reset_n=0.

Decomposition:
- Shared package/include: WORD_SIZE, NUM_REGS, reg-index width, and the grant-source encoding (GNT_NONE=0, GNT_WB=1, GNT_AUX=2), for use by the hazard unit and testbench.
- Sub-module: sync_fifo (parameterised width/depth, async active-low reset, count output). The arbiter top holds the grant mux, age counter, mask and error logic.

Test Plan:
- Reset: hold reset_n=0 mid-queue with count=2, then release -> count=0, aux_ready=1, pending_mask=0000, rf_reg_write=0, collision_err=0.
- Idle drain: wb_valid=0; AUX pushes (dest=2, 0x1234) at edge N -> pending_mask=0100 after N; rf_reg_write=1, rf_dest=2, rf_write_data=0x1234 in the next cycle; mask back to 0000 after the following edge.
- WB priority: wb_valid=1 continuously (dest=1, 0xAAAA); AUX pushes (dest=3, 0x5555) at N -> WB is written for cycles N+1..N+4. At age=4, wb_stall=1 and rf_dest=3/0x5555. The next cycle WB is re-written with 0xAAAA and wb_stall=0.
- Full FIFO: with wb_valid=1, push two AUX entries -> aux_ready=0. A third aux_valid is held and not accepted until after the first stall-grant dequeue. Entries then drain in order (dest 0, then dest 1).
- Simultaneous: count=1 with head granted while a new AUX entry is pushed in the same edge -> count stays 1 and the new entry is written the next free cycle.
- Collision: queue AUX dest=2, then present wb_valid=1, wb_dest=2 -> WB write occurs and collision_err=1 after that edge, remaining 1 until reset.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-write constants and grant-source encoding for the arbiter,
// the hazard unit and the verification bench.
package regfile_wr_arbiter_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_AUX  = 2'd2
  } gnt_src_e;

  typedef struct packed {
    reg_idx_t dest;
    word_t    data;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; 1-cycle write-to-read.
// Caller must not push when full or pop when empty; count exposes occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB zero-latency priority, AUX queued (>=1 cycle),
// starvation stall on WB; aux_ready drops when the queue is full, no pass-through.
module regfile_wr_arbiter #(
  parameter int WORD_SIZE    = regfile_wr_arbiter_pkg::WORD_SIZE,
  parameter int NUM_REGS     = regfile_wr_arbiter_pkg::NUM_REGS,
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int REG_W        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_valid,
  input  logic [REG_W-1:0]     wb_dest,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 wb_stall,
  input  logic                 aux_valid,
  output logic                 aux_ready,
  input  logic [REG_W-1:0]     aux_dest,
  input  logic [WORD_SIZE-1:0] aux_data,
  output logic                 rf_reg_write,
  output logic [REG_W-1:0]     rf_dest,
  output logic [WORD_SIZE-1:0] rf_write_data,
  output logic [NUM_REGS-1:0]  pending_mask,
  output logic                 collision_err
);

  import regfile_wr_arbiter_pkg::*;

  localparam int CNT_W  = $clog2(AUX_DEPTH + 1);
  localparam int AGE_W  = $clog2(STARVE_LIMIT + 1);
  localparam int FIFO_W = REG_W + WORD_SIZE;

  logic [CNT_W-1:0]     count;
  logic [FIFO_W-1:0]    head_dat;
  logic [REG_W-1:0]     head_dest;
  logic [WORD_SIZE-1:0] head_data;
  logic                 aux_push;
  logic                 aux_pop;
  logic                 head_vld;
  logic [AGE_W-1:0]     age;
  logic [AGE_W-1:0]     age_nxt;
  logic [CNT_W-1:0]     pend_cnt [NUM_REGS];
  gnt_src_e             gnt_src;

  assign head_vld  = (count != '0);
  assign head_dest = head_dat[FIFO_W-1:WORD_SIZE];
  assign head_data = head_dat[WORD_SIZE-1:0];

  assign aux_ready = (count < CNT_W'(AUX_DEPTH));
  assign aux_push  = aux_valid && aux_ready;
  assign wb_stall  = head_vld && (age >= AGE_W'(STARVE_LIMIT));
  assign aux_pop   = (gnt_src == GNT_AUX);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (AUX_DEPTH)
  ) u_aux_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (aux_push),
    .push_dat ({aux_dest, aux_data}),
    .pop      (aux_pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_comb begin
    gnt_src       = GNT_NONE;
    rf_reg_write  = 1'b0;
    rf_dest       = '0;
    rf_write_data = '0;
    if (wb_stall) begin
      gnt_src = GNT_AUX;
    end else if (wb_valid) begin
      gnt_src = GNT_WB;
    end else if (head_vld) begin
      gnt_src = GNT_AUX;
    end
    case (gnt_src)
      GNT_WB: begin
        rf_reg_write  = 1'b1;
        rf_dest       = wb_dest;
        rf_write_data = wb_data;
      end
      GNT_AUX: begin
        rf_reg_write  = 1'b1;
        rf_dest       = head_dest;
        rf_write_data = head_data;
      end
      default: ;
    endcase
  end

  // Age only counts cycles the head waits; any drain restarts it so WB
  // regains a full window of priority before the next forced slot.
  always_comb begin
    age_nxt = age;
    if (aux_pop || !head_vld) begin
      age_nxt = '0;
    end else if (age < AGE_W'(STARVE_LIMIT)) begin
      age_nxt = age + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age <= '0;
    end else begin
      age <= age_nxt;
    end
  end

  // Per-register occupancy counts keep the mask exact with repeated dests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        case ({aux_push && (aux_dest == REG_W'(r)), aux_pop && (head_dest == REG_W'(r))})
          2'b10:   pend_cnt[r] <= pend_cnt[r] + 1'b1;
          2'b01:   pend_cnt[r] <= pend_cnt[r] - 1'b1;
          default: pend_cnt[r] <= pend_cnt[r];
        endcase
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (pend_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision_err <= 1'b0;
    end else if ((gnt_src == GNT_WB) && pending_mask[wb_dest]) begin
      collision_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a queue-based model.
module tb_regfile_wr_arbiter;

  localparam int WS    = 16;
  localparam int NR    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [1:0]  dest;
    logic [15:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wb_valid = 1'b0;
  logic [1:0]    wb_dest = '0;
  logic [WS-1:0] wb_data = '0;
  logic          wb_stall;
  logic          aux_valid = 1'b0;
  logic          aux_ready;
  logic [1:0]    aux_dest = '0;
  logic [WS-1:0] aux_data = '0;
  logic          rf_reg_write;
  logic [1:0]    rf_dest;
  logic [WS-1:0] rf_write_data;
  logic [NR-1:0] pending_mask;
  logic          collision_err;

  int checks = 0;
  int failures = 0;

  ent_t q[$];
  int   m_age = 0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .WORD_SIZE    (WS),
    .NUM_REGS     (NR),
    .AUX_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .wb_stall      (wb_stall),
    .aux_valid     (aux_valid),
    .aux_ready     (aux_ready),
    .aux_dest      (aux_dest),
    .aux_data      (aux_data),
    .rf_reg_write  (rf_reg_write),
    .rf_dest       (rf_dest),
    .rf_write_data (rf_write_data),
    .pending_mask  (pending_mask),
    .collision_err (collision_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_aux_ready", {31'd0, aux_ready}, 32'd1);
    chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
    chk("rst_rf_dest", {30'd0, rf_dest}, 32'd0);
    chk("rst_rf_write_data", {16'd0, rf_write_data}, 32'd0);
    chk("rst_pending_mask", {28'd0, pending_mask}, 32'd0);
    chk("rst_collision_err", {31'd0, collision_err}, 32'd0);
  endtask

  // Entered just after a posedge; asserts reset at once, releases it on a negedge.
  task automatic do_reset();
    wb_valid  = 1'b0;
    aux_valid = 1'b0;
    reset_n   = 1'b0;
    q.delete();
    m_age = 0;
    m_err = 1'b0;
    #1;
    chk_reset_state();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic wv, input logic [1:0] wd, input logic [15:0] wdat,
                      input logic av, input logic [1:0] ad, input logic [15:0] adat,
                      output logic acc, output logic stalled);
    logic          e_ready, e_stall, e_we, wb_hit;
    logic [1:0]    e_dest;
    logic [15:0]   e_data;
    logic [NR-1:0] e_mask;
    int            src;
    wb_valid = wv; wb_dest = wd; wb_data = wdat;
    aux_valid = av; aux_dest = ad; aux_data = adat;

    e_ready = (q.size() < DEPTH);
    e_stall = (q.size() > 0) && (m_age >= LIMIT);
    e_mask  = '0;
    wb_hit  = 1'b0;
    foreach (q[i]) begin
      e_mask[q[i].dest] = 1'b1;
      if (q[i].dest == wd) wb_hit = 1'b1;
    end
    if (e_stall)          src = 2;
    else if (wv)          src = 1;
    else if (q.size() > 0) src = 2;
    else                  src = 0;
    e_we = (src != 0);
    e_dest = (src == 1) ? wd : (src == 2) ? q[0].dest : 2'd0;
    e_data = (src == 1) ? wdat : (src == 2) ? q[0].data : 16'd0;

    @(negedge clk);
    chk("aux_ready", {31'd0, aux_ready}, {31'd0, e_ready});
    chk("wb_stall", {31'd0, wb_stall}, {31'd0, e_stall});
    chk("rf_reg_write", {31'd0, rf_reg_write}, {31'd0, e_we});
    chk("rf_dest", {30'd0, rf_dest}, {30'd0, e_dest});
    chk("rf_write_data", {16'd0, rf_write_data}, {16'd0, e_data});
    chk("pending_mask", {28'd0, pending_mask}, {28'd0, e_mask});
    chk("collision_err", {31'd0, collision_err}, {31'd0, m_err});

    @(posedge clk);
    if (src == 1 && wb_hit) m_err = 1'b1;
    if (src == 2) begin
      void'(q.pop_front());
      m_age = 0;
    end else if (q.size() > 0) begin
      m_age = (m_age < LIMIT) ? m_age + 1 : LIMIT;
    end else begin
      m_age = 0;
    end
    acc = av && e_ready;
    if (acc) q.push_back('{dest: ad, data: adat});
    stalled = e_stall;
    #1;
  endtask

  initial begin
    logic acc, st;
    logic       hv;
    logic [1:0] hd;
    logic [15:0] hdat;
    logic       av;
    logic [1:0] ad;
    logic [15:0] adat;

    #1;
    do_reset();

    // Idle drain.
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 16'h1234, acc, st);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, acc, st);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, acc, st);

    // WB priority then forced AUX slot and WB re-presentation.
    step(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd3, 16'h5555, acc, st);
    for (int i = 0; i < 7; i++) step(1'b1, 2'd1, 16'hAAAA, 1'b0, 2'd0, 16'h0, acc, st);

    // Full FIFO: third entry held until space appears, then ordered drain.
    step(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd0, 16'h0A0A, acc, st);
    step(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd1, 16'h1B1B, acc, st);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd2, 16'h2C2C, acc, st);
    chk("third_push_accepted", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 14; i++) step(1'b1, 2'd1, 16'hAAAA, 1'b0, 2'd0, 16'h0, acc, st);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, acc, st);

    // Simultaneous enqueue and dequeue at count=1.
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 16'h3333, acc, st);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 16'h4444, acc, st);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, acc, st);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, acc, st);

    // Reset mid-queue with two entries held behind WB.
    step(1'b1, 2'd0, 16'h7777, 1'b1, 2'd2, 16'h0101, acc, st);
    step(1'b1, 2'd0, 16'h7777, 1'b1, 2'd3, 16'h0202, acc, st);
    do_reset();

    // Collision: WB targets a queued register; error is sticky.
    step(1'b1, 2'd1, 16'h9999, 1'b1, 2'd2, 16'hBEEF, acc, st);
    step(1'b1, 2'd2, 16'hCAFE, 1'b0, 2'd0, 16'h0, acc, st);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, acc, st);
    do_reset();

    // Randomized traffic; a stalled WB request is re-presented unchanged.
    st = 1'b0; acc = 1'b1;
    hv = 1'b0; hd = '0; hdat = '0;
    av = 1'b0; ad = '0; adat = '0;
    for (int i = 0; i < 600; i++) begin
      if (!st) begin
        hv   = ($urandom_range(0, 99) < 65);
        hd   = 2'($urandom_range(0, 3));
        hdat = 16'($urandom);
      end
      if (acc || !av) begin
        av   = ($urandom_range(0, 99) < 35);
        ad   = 2'($urandom_range(0, 3));
        adat = 16'($urandom);
      end
      step(hv, hd, hdat, av, ad, adat, acc, st);
      if (i == 300) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
